hazard_ctrl_unit: RTL

//  Next-generation pipeline hazard controller for the 5-stage RISC-V core.
//  - Generalises EX-stage operand forwarding to NUM_SRC source operands.
//  - Adds load-use stall detection with a multi-cycle stall FSM for loads of

---
 rtl/hazard_ctrl_unit.sv | 131 +++++++++++++
 1 files changed

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the 5-stage core: EX operand forwarding, load-use stall FSM, branch flush.
// Optional perf counters (stall_cnt/flush_cnt) are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl_unit #(
  parameter int AW       = 5,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  RegWrite_M,
  input  logic                  RegWrite_W,
  input  logic [AW-1:0]         rd_M,
  input  logic [AW-1:0]         rd_W,
  input  logic [NUM_SRC*AW-1:0] rs_E,
  input  logic [NUM_SRC*AW-1:0] rs_D,
  input  logic [NUM_SRC-1:0]    rs_used_D,
  input  logic                  MemRead_E,
  input  logic [AW-1:0]         rd_E,
  input  logic                  PCSrc_E,
  output logic [2*NUM_SRC-1:0]  Forward_E,
  output logic                  Stall_F,
  output logic                  Stall_D,
  output logic                  Flush_D,
  output logic                  Flush_E
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
`endif
);

  typedef enum logic {RUN, LSTALL} state_t;

  // The RUN cycle that detects the hit is the first stall cycle.
  localparam logic [7:0] CNT_INIT = (LOAD_LAT > 1) ? 8'(LOAD_LAT - 2) : 8'd0;

  state_t                 state_q, state_d;
  logic   [7:0]           cnt_q, cnt_d;
  logic   [2*NUM_SRC-1:0] fwd_c;
  logic                   lu_hit;
  logic                   stall_c, flush_d_c, flush_e_c;

  always_comb begin
    fwd_c  = '0;
    lu_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (RegWrite_M && rd_M != '0 && rd_M == rs_E[i*AW +: AW])
        fwd_c[2*i +: 2] = 2'b10;
      else if (RegWrite_W && rd_W != '0 && rd_W == rs_E[i*AW +: AW])
        fwd_c[2*i +: 2] = 2'b01;
      if (rs_used_D[i] && rs_D[i*AW +: AW] == rd_E)
        lu_hit = 1'b1;
    end
    lu_hit = lu_hit && MemRead_E && (rd_E != '0);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_c   = 1'b0;
    flush_d_c = 1'b0;
    flush_e_c = 1'b0;
    case (state_q)
      RUN: begin
        if (PCSrc_E) begin
          flush_d_c = 1'b1;
          flush_e_c = 1'b1;
        end else if (lu_hit) begin
          stall_c   = 1'b1;
          flush_e_c = 1'b1;
          if (LOAD_LAT > 1) begin
            state_d = LSTALL;
            cnt_d   = CNT_INIT;
          end
        end
      end
      LSTALL: begin
        if (PCSrc_E) begin
          flush_d_c = 1'b1;
          flush_e_c = 1'b1;
          state_d   = RUN;
        end else begin
          stall_c   = 1'b1;
          flush_e_c = 1'b1;
          if (cnt_q == 8'd0) state_d = RUN;
          else               cnt_d   = cnt_q - 8'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Gating with rst_n makes every output drop the moment reset is asserted.
  assign Forward_E = rst_n ? fwd_c : '0;
  assign Stall_F   = rst_n & stall_c;
  assign Stall_D   = rst_n & stall_c;
  assign Flush_D   = rst_n & flush_d_c;
  assign Flush_E   = rst_n & flush_e_c;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (Stall_F && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (Flush_D && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  logic unused_cnt_w;
  assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule
